// File: rtl/stream_video_pkg.sv
// Shared types and constants for the video test-pattern generator.
// Holds the FSM encoding, pattern-select codes and pixel/coordinate widths.
package stream_video_pkg;

  localparam int PIXEL_W = 24;
  localparam int COORD_W = 12;

  typedef logic [PIXEL_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

  localparam logic [1:0] PAT_BARS    = 2'd0;
  localparam logic [1:0] PAT_GRAD    = 2'd1;
  localparam logic [1:0] PAT_CHECKER = 2'd2;
  localparam logic [1:0] PAT_SOLID   = 2'd3;

endpackage

// File: rtl/stream_video_pattern_pixel.sv
// Combinational pixel function: coordinate, pattern mode and solid colour
// in, one 24-bit RGB value out.
module stream_video_pattern_pixel
  import stream_video_pkg::*;
#(
  parameter int BAR_SHIFT = 3
) (
  input  logic [COORD_W-1:0] x,
  input  logic [7:0]         y,
  input  logic [1:0]         mode,
  input  pixel_t             color,
  output pixel_t             data
);

  logic [2:0] bar;
  logic [7:0] sum;

  always_comb begin
    bar  = 3'(x >> BAR_SHIFT);
    sum  = x[7:0] + y;
    data = '0;
    case (mode)
      PAT_BARS:    data = {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
      PAT_GRAD:    data = {x[7:0], y, sum};
      PAT_CHECKER: data = (x[3] ^ y[3]) ? 24'hFF_FFFF : 24'h00_0000;
      PAT_SOLID:   data = color;
      default:     data = '0;
    endcase
  end

endmodule

// File: rtl/stream_video_pattern_gen.sv
// AXI4-Stream video test-pattern source: one frame per enable request,
// optional idle gap after each frame, all outputs registered.
//
// state     | meaning
// ST_IDLE   | waiting for enable; tvalid low
// ST_ACTIVE | streaming pixels of the current frame
// ST_GAP    | FRAME_GAP idle cycles after a frame, tvalid low
module stream_video_pattern_gen
  import stream_video_pkg::*;
#(
  parameter int FRAME_WIDTH  = 64,
  parameter int FRAME_HEIGHT = 48,
  parameter int FRAME_GAP    = 4,
  parameter int BAR_SHIFT    = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [1:0]         pattern_sel,
  input  logic [PIXEL_W-1:0] solid_color,
  output logic [PIXEL_W-1:0] m_axis_video_tdata,
  output logic               m_axis_video_tvalid,
  output logic               m_axis_video_tuser,
  output logic               m_axis_video_tlast,
  input  logic               m_axis_video_tready,
  output logic [15:0]        frame_cnt,
  output logic               busy
);

  localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(FRAME_WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(FRAME_HEIGHT - 1);
  localparam logic [COORD_W-1:0] COORD_1  = COORD_W'(1);
  localparam logic [15:0]        GAP_LOAD = 16'(FRAME_GAP);

  state_t               state, state_n;
  logic [COORD_W-1:0]   x, y, x_n, y_n, x_inc, y_inc, pix_x;
  logic [7:0]           pix_y;
  logic [15:0]          gap_cnt, gap_n, frame_n;
  logic [1:0]           mode, mode_n, pix_mode;
  pixel_t               color, color_n, pix_color, pix, data_n;
  logic                 valid_n, user_n, last_n, busy_n;
  logic                 line_end, frame_end, fire;

  assign fire      = m_axis_video_tvalid && m_axis_video_tready;
  assign line_end  = (x == X_LAST);
  assign frame_end = line_end && (y == Y_LAST);
  assign x_inc     = line_end ? '0 : x + COORD_1;
  assign y_inc     = line_end ? ((y == Y_LAST) ? '0 : y + COORD_1) : y;

  // In IDLE the first pixel is built from the live inputs, since the latch
  // of pattern_sel/solid_color happens on the same edge.
  assign pix_x     = (state == ST_IDLE) ? '0 : x_inc;
  assign pix_y     = (state == ST_IDLE) ? 8'd0 : y_inc[7:0];
  assign pix_mode  = (state == ST_IDLE) ? pattern_sel : mode;
  assign pix_color = (state == ST_IDLE) ? solid_color : color;

  stream_video_pattern_pixel #(
    .BAR_SHIFT(BAR_SHIFT)
  ) u_pixel (
    .x    (pix_x),
    .y    (pix_y),
    .mode (pix_mode),
    .color(pix_color),
    .data (pix)
  );

  always_comb begin
    state_n = state;
    x_n     = x;
    y_n     = y;
    gap_n   = gap_cnt;
    frame_n = frame_cnt;
    mode_n  = mode;
    color_n = color;
    valid_n = m_axis_video_tvalid;
    user_n  = m_axis_video_tuser;
    last_n  = m_axis_video_tlast;
    data_n  = m_axis_video_tdata;
    case (state)
      ST_IDLE: begin
        if (enable) begin
          state_n = ST_ACTIVE;
          mode_n  = pattern_sel;
          color_n = solid_color;
          x_n     = '0;
          y_n     = '0;
          valid_n = 1'b1;
          user_n  = 1'b1;
          last_n  = 1'b0;
          data_n  = pix;
        end
      end
      ST_ACTIVE: begin
        if (fire) begin
          if (frame_end) begin
            frame_n = frame_cnt + 16'd1;
            valid_n = 1'b0;
            user_n  = 1'b0;
            last_n  = 1'b0;
            x_n     = '0;
            y_n     = '0;
            if (FRAME_GAP > 0) begin
              state_n = ST_GAP;
              gap_n   = GAP_LOAD;
            end else begin
              state_n = ST_IDLE;
            end
          end else begin
            x_n    = x_inc;
            y_n    = y_inc;
            user_n = 1'b0;
            last_n = (x_inc == X_LAST);
            data_n = pix;
          end
        end
      end
      ST_GAP: begin
        gap_n = gap_cnt - 16'd1;
        if (gap_cnt <= 16'd1) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign busy_n = (state_n != ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state               <= ST_IDLE;
      x                   <= '0;
      y                   <= '0;
      gap_cnt             <= '0;
      frame_cnt           <= '0;
      mode                <= PAT_BARS;
      color               <= '0;
      m_axis_video_tvalid <= 1'b0;
      m_axis_video_tuser  <= 1'b0;
      m_axis_video_tlast  <= 1'b0;
      m_axis_video_tdata  <= '0;
      busy                <= 1'b0;
    end else begin
      state               <= state_n;
      x                   <= x_n;
      y                   <= y_n;
      gap_cnt             <= gap_n;
      frame_cnt           <= frame_n;
      mode                <= mode_n;
      color               <= color_n;
      m_axis_video_tvalid <= valid_n;
      m_axis_video_tuser  <= user_n;
      m_axis_video_tlast  <= last_n;
      m_axis_video_tdata  <= data_n;
      busy                <= busy_n;
    end
  end

endmodule

// File: tb/tb_stream_video_pattern_gen.sv
// Scoreboard bench for the video pattern generator: frames are predicted
// from the pattern rules when requested and checked by a negedge monitor.
module tb_stream_video_pattern_gen;

  localparam int W   = 16;
  localparam int H   = 3;
  localparam int GAP = 4;
  localparam int BS  = 1;

  typedef struct {
    logic [23:0] data;
    logic        user;
    logic        last;
    logic        eof;
    int          gap;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic [23:0] solid_color;
  logic [23:0] tdata;
  logic        tvalid, tuser, tlast, tready;
  logic [15:0] frame_cnt;
  logic        busy;

  int    checks = 0;
  int    failures = 0;
  int    frames_exp = 0;
  int    ready_mode = 0;
  int    low_run = 0;
  beat_t q[$];

  logic        pv = 1'b0, pr = 1'b0, pu = 1'b0, pl = 1'b0;
  logic [23:0] pd = '0;

  stream_video_pattern_gen #(
    .FRAME_WIDTH (W),
    .FRAME_HEIGHT(H),
    .FRAME_GAP   (GAP),
    .BAR_SHIFT   (BS)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .enable             (enable),
    .pattern_sel        (pattern_sel),
    .solid_color        (solid_color),
    .m_axis_video_tdata (tdata),
    .m_axis_video_tvalid(tvalid),
    .m_axis_video_tuser (tuser),
    .m_axis_video_tlast (tlast),
    .m_axis_video_tready(tready),
    .frame_cnt          (frame_cnt),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference pixel, straight from the pattern definitions.
  function automatic logic [23:0] ref_pixel(int px, int py, int mode, logic [23:0] c);
    int bar;
    logic [7:0] r, g, b;
    case (mode)
      0: begin
        bar = (px / (1 << BS)) % 8;
        r = ((bar / 4) % 2 == 1) ? 8'hFF : 8'h00;
        g = ((bar / 2) % 2 == 1) ? 8'hFF : 8'h00;
        b = (bar % 2 == 1) ? 8'hFF : 8'h00;
        return {r, g, b};
      end
      1: return {8'(px % 256), 8'(py % 256), 8'((px + py) % 256)};
      2: return ((((px / 8) + (py / 8)) % 2) == 1) ? 24'hFFFFFF : 24'h000000;
      default: return c;
    endcase
  endfunction

  task automatic push_frame(input int mode, input logic [23:0] c, input int gap_exp);
    beat_t b;
    for (int py = 0; py < H; py++) begin
      for (int px = 0; px < W; px++) begin
        b.data = ref_pixel(px, py, mode, c);
        b.user = (px == 0 && py == 0);
        b.last = (px == W - 1);
        b.eof  = (px == W - 1 && py == H - 1);
        b.gap  = (px == 0 && py == 0) ? gap_exp : -1;
        q.push_back(b);
      end
    end
  endtask

  task automatic start_frame(input logic [1:0] p, input logic [23:0] c, input int gap_exp,
                             input bit hold);
    @(posedge clk); #1;
    enable      = 1'b1;
    pattern_sel = p;
    solid_color = c;
    push_frame(int'(p), c, gap_exp);
    if (!hold) begin
      @(posedge clk); #1;
      enable      = 1'b0;
      pattern_sel = 2'($urandom);
      solid_color = 24'($urandom);
    end
  endtask

  task automatic wait_queue_below(input int n, input string name);
    int i;
    for (i = 0; i < 5000 && q.size() > n; i++) @(negedge clk);
    if (q.size() > n) begin
      checks++;
      failures++;
      $display("FAIL %s timeout actual_left=%0d required_max=%0d", name, q.size(), n);
      q.delete();
    end
  endtask

  task automatic settle(input string name);
    wait_queue_below(0, name);
    repeat (GAP + 4) @(posedge clk);
    #1 check({name, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  always begin
    @(posedge clk); #1;
    case (ready_mode)
      0:       tready = 1'b1;
      1:       tready = ~tready;
      default: tready = ($urandom % 3) != 0;
    endcase
  end

  always @(negedge clk) begin
    beat_t e;
    if (!reset) begin
      pv = 1'b0; pr = 1'b0; low_run = 0;
    end else begin
      check("frame_cnt", 32'(frame_cnt), 32'(frames_exp[15:0]));
      if (pv && !pr) begin
        check("stall_valid", 32'(tvalid), 32'd1);
        check("stall_data", {8'd0, tdata}, {8'd0, pd});
        check("stall_flags", {30'd0, tuser, tlast}, {30'd0, pu, pl});
      end
      if (tvalid) begin
        check("busy_active", 32'(busy), 32'd1);
        if (!pv && q.size() > 0 && q[0].gap >= 0)
          check("gap_low_cycles", 32'(low_run), 32'(q[0].gap));
        if (tready) begin
          if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat actual=%h required=none", tdata);
          end else begin
            e = q.pop_front();
            check("tdata", {8'd0, tdata}, {8'd0, e.data});
            check("tuser", 32'(tuser), 32'(e.user));
            check("tlast", 32'(tlast), 32'(e.last));
            if (e.eof) begin
              frames_exp++;
              low_run = 0;
            end
          end
        end
      end else begin
        low_run++;
      end
      pv = tvalid; pr = tready; pd = tdata; pu = tuser; pl = tlast;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; enable = 1'b0; pattern_sel = 2'd0; solid_color = '0; tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 32'(tvalid), 32'd0);
    check("rst_tuser", 32'(tuser), 32'd0);
    check("rst_tlast", 32'(tlast), 32'd0);
    check("rst_tdata", {8'd0, tdata}, 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);

    // Directed: each pattern with a different ready behaviour.
    ready_mode = 0; start_frame(2'd0, 24'h0, -1, 0); settle("bars");
    ready_mode = 1; start_frame(2'd1, 24'h0, -1, 0); settle("grad");
    ready_mode = 2; start_frame(2'd2, 24'h0, -1, 0); settle("checker");

    // Solid frame with select and enable dropped mid-frame.
    start_frame(2'd3, 24'h123456, -1, 0);
    pattern_sel = 2'd0;
    repeat (10) @(posedge clk);
    #1 solid_color = 24'hABCDEF;
    settle("solid");
    repeat (60) @(posedge clk);
    #1 check("no_extra_frame_busy", 32'(busy), 32'd0);

    // Randomized frames.
    for (int i = 0; i < 6; i++) begin
      ready_mode = int'($urandom_range(0, 2));
      start_frame(2'($urandom), 24'($urandom), -1, 0);
      settle("random");
    end

    // Back-to-back frames with enable held: gap must be GAP+1 low cycles.
    ready_mode = 2;
    begin
      logic [1:0]  p;
      logic [23:0] c;
      p = 2'($urandom);
      c = 24'($urandom);
      start_frame(p, c, -1, 1);
      push_frame(int'(p), c, GAP + 1);
      wait_queue_below(W * H, "b2b_first");
      repeat (GAP + 3) @(posedge clk);
      #1 enable = 1'b0;
      pattern_sel = 2'($urandom);
      settle("b2b");
    end

    // Reset in the middle of a line.
    ready_mode = 0;
    start_frame(2'd1, 24'h0, -1, 0);
    repeat (18) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst_tvalid", 32'(tvalid), 32'd0);
    check("midrst_tdata", {8'd0, tdata}, 32'd0);
    check("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    q.delete();
    frames_exp = 0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    ready_mode = 2;
    start_frame(2'd2, 24'h0, -1, 0);
    settle("post_reset");
    check("post_reset_frames", 32'(frame_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_video_pattern_gen.md
STREAM_VIDEO_PATTERN_GEN -- requirements
Module: stream_video_pattern_gen

Interface
REQ-001 SHALL have parameter FRAME_WIDTH, default 64, active pixels per line (2..4095).
REQ-002 SHALL have parameter FRAME_HEIGHT, default 48, active lines per frame (2..4095).
REQ-003 SHALL have parameter FRAME_GAP, default 4, idle cycles after each frame (0..65535).
REQ-004 SHALL have parameter BAR_SHIFT, default 3, log2 of colour-bar width in pixels.
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port enable  input  1  run request; sampled only in IDLE.
REQ-008 SHALL have port pattern_sel  input  2  0 bars, 1 gradient, 2 checker, 3 solid.
REQ-009 SHALL have port solid_color  input  24  colour for pattern 3.
REQ-010 SHALL have ports m_axis_video_tdata/tvalid/tuser/tlast  output  24/1/1/1  video data, valid, start of frame, end of line.
REQ-011 SHALL have port m_axis_video_tready  input  1  downstream ready.
REQ-012 SHALL have port frame_cnt  output  16  completed frames, wraps 0xFFFF->0.
REQ-013 SHALL have port busy  output  1  high in ACTIVE or GAP.

Function
REQ-014 SHALL implement FSM states IDLE, ACTIVE, GAP.
REQ-015 IDLE with enable=1 SHALL go to ACTIVE, latching pattern_sel and solid_color and presenting pixel (x=0,y=0) with tvalid=1 on the next cycle.
REQ-016 Transfer SHALL be tvalid&&tready; x increments per transfer, wraps to 0 after FRAME_WIDTH-1, then y increments.
REQ-017 While tvalid=1 and tready=0, tdata/tuser/tlast SHALL be held stable.
REQ-018 tuser SHALL be 1 only on pixel (0,0); tlast SHALL be 1 only on x=FRAME_WIDTH-1.
REQ-019 Transfer of pixel (FRAME_WIDTH-1,FRAME_HEIGHT-1) SHALL increment frame_cnt, drop tvalid next cycle, enter GAP if FRAME_GAP>0 else IDLE.
REQ-020 GAP SHALL last exactly FRAME_GAP cycles with tvalid=0, then IDLE; inter-frame tvalid-low time = FRAME_GAP+1 cycles.
REQ-021 enable deasserted in ACTIVE/GAP SHALL NOT truncate the frame; generator stops in IDLE.
REQ-022 pattern_sel/solid_color changes mid-frame SHALL NOT affect the current frame.
REQ-023 Pattern 0: bar=(x>>BAR_SHIFT) mod 8; tdata[23:16],[15:8],[7:0] = 0xFF if bar bit 2,1,0 set, else 0x00.
REQ-024 Pattern 1: tdata = {x[7:0], y[7:0], (x+y) mod 256}.
REQ-025 Pattern 2: tdata = 0xFFFFFF if (x[3]^y[3])=1, else 0x000000.
REQ-026 Pattern 3: tdata = latched solid_color.
REQ-027 All outputs SHALL be registered; no combinational path from tready to any output.

Reset
REQ-028 reset=0 SHALL asynchronously force IDLE, x=y=0, gap counter 0, frame_cnt=0, tvalid=tuser=tlast=0, tdata=0, busy=0.
REQ-029 Reset mid-frame SHALL abort; after release first frame starts at (0,0) with tuser=1.

Structure
REQ-030 State encoding, pattern-select constants and 24-bit pixel width SHALL live in package stream_video_pkg.
REQ-031 Pixel function (x, y, mode, colour -> 24-bit) SHALL be sub-module stream_video_pattern_pixel.

Verification
REQ-032 W=4,H=2,GAP=0, pattern 1, tready=1 -> 8 beats, tdata 0x000000,0x010001,0x020002,0x030003,0x000101..0x030104; tuser beat 0; tlast beats 3,7; frame_cnt=1.
REQ-033 Same, tready toggled 1/0 each cycle -> identical beat sequence, data stable while stalled.
REQ-034 W=16,H=2, pattern 0, BAR_SHIFT=1 -> x=0..1 0x000000, x=2..3 0x0000FF, x=14..15 0xFFFFFF.
REQ-035 GAP=4, enable held 1 -> exactly 5 tvalid-low cycles between last and next first beat; frame_cnt increments once per frame.
REQ-036 pattern_sel 3->0 and enable 1->0 mid-frame, solid_color=0x123456 -> frame completes all 0x123456, no further frames.
REQ-037 reset pulsed low mid-line -> tvalid=0 immediately; next frame starts (0,0) with tuser=1, frame_cnt=0.
